// File: rtl/alu_seq_if.sv
// Operand-issue / result-consumer handshake bundle for alu_seq.
// master = issuing side, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         sel;
  logic               sgn;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;
  logic               zero;
  logic               ovf;

  modport master (
    output in_valid, a, b, sel, sgn, out_ready,
    input  in_ready, out_valid, y, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, sel, sgn, out_ready,
    output in_ready, out_valid, y, zero, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/logic/shift, W-cycle shift-add multiply.
// Optional macro ALU_SAT_EN clamps overflowing add/sub/mul results to the W-bit range.
module alu_seq #(
  parameter int WIDTH = 10
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_reg, state_next;
  logic             sgn_reg, sgn_next;
  logic             neg_reg, neg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2*W-1:0]   acc_reg, acc_next;
  logic [2*W-1:0]   mcand_reg, mcand_next;
  logic [W-1:0]     mplier_reg, mplier_next;
  logic [2*W-1:0]   y_reg, y_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;

  logic             in_ready;
  logic             accept;
  logic             retire;
  logic [2*W-1:0]   ext_a, ext_b;
  logic [W-1:0]     sra;
  logic [W-1:0]     mag_a, mag_b;
  logic [2*W-1:0]   alu_raw;
  logic [2*W-1:0]   acc_step;
  logic [2*W-1:0]   fin_raw;
  logic             fin_arith;
  logic             fin_sgn;
  logic [2*W-1:0]   fin_y;
  logic             fin_zero;
  logic             fin_ovf;

  assign in_ready      = (state_reg == IDLE) && !rst;
  assign accept        = bus.in_valid && in_ready;
  assign retire        = (state_reg == DONE) && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.y         = y_reg;
  assign bus.zero      = zero_reg;
  assign bus.ovf       = ovf_reg;

  // Operand extension to 2W: upper bits replicate the sign only in signed mode.
  assign ext_a[W-1:0] = bus.a;
  assign ext_b[W-1:0] = bus.b;
  generate
    for (genvar gi = W; gi < 2*W; gi++) begin : g_ext
      assign ext_a[gi] = bus.sgn & bus.a[W-1];
      assign ext_b[gi] = bus.sgn & bus.b[W-1];
    end
  endgenerate

  assign sra   = $signed(bus.a) >>> bus.b;
  assign mag_a = (bus.sgn && bus.a[W-1]) ? (~bus.a + W'(1)) : bus.a;
  assign mag_b = (bus.sgn && bus.b[W-1]) ? (~bus.b + W'(1)) : bus.b;

  always_comb begin
    alu_raw = '0;
    case (bus.sel)
      OP_ADD: alu_raw = ext_a + ext_b;
      OP_SUB: alu_raw = ext_a - ext_b;
      OP_XOR: alu_raw = {{W{1'b0}}, bus.a ^ bus.b};
      OP_AND: alu_raw = {{W{1'b0}}, bus.a & bus.b};
      OP_OR:  alu_raw = {{W{1'b0}}, bus.a | bus.b};
      OP_SHL: alu_raw = {{W{1'b0}}, bus.a} << bus.b;
      OP_SHR: alu_raw = bus.sgn ? {{W{sra[W-1]}}, sra} : {{W{1'b0}}, bus.a >> bus.b};
      default: alu_raw = '0;
    endcase
  end

  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Result finishing shared by the single-cycle path and the last multiply step.
  always_comb begin
    if (state_reg == MUL) begin
      fin_raw   = neg_reg ? ('0 - acc_step) : acc_step;
      fin_arith = 1'b1;
      fin_sgn   = sgn_reg;
    end else begin
      fin_raw   = alu_raw;
      fin_arith = (bus.sel == OP_ADD) || (bus.sel == OP_SUB);
      fin_sgn   = bus.sgn;
    end
    if (fin_sgn)
      fin_ovf = fin_arith && (fin_raw[2*W-1:W-1] != {(W+1){fin_raw[2*W-1]}});
    else
      fin_ovf = fin_arith && (|fin_raw[2*W-1:W]);
    fin_y = fin_raw;
`ifdef ALU_SAT_EN
    if (fin_ovf) begin
      if (fin_sgn)
        fin_y = fin_raw[2*W-1] ? {{(W+1){1'b1}}, {(W-1){1'b0}}}
                               : {{(W+1){1'b0}}, {(W-1){1'b1}}};
      else if ((state_reg != MUL) && (bus.sel == OP_SUB))
        fin_y = '0;
      else
        fin_y = {{W{1'b0}}, {W{1'b1}}};
    end
`endif
    fin_zero = (fin_y == '0);
  end

  always_comb begin
    state_next  = state_reg;
    sgn_next    = sgn_reg;
    neg_next    = neg_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    y_next      = y_reg;
    zero_next   = zero_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          sgn_next = bus.sgn;
          if (bus.sel == OP_MUL) begin
            mcand_next  = {{W{1'b0}}, mag_a};
            mplier_next = mag_b;
            acc_next    = '0;
            cnt_next    = '0;
            neg_next    = bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
            state_next  = MUL;
          end else begin
            y_next     = fin_y;
            zero_next  = fin_zero;
            ovf_next   = fin_ovf;
            state_next = DONE;
          end
        end
      end
      MUL: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == CW'(W-1)) begin
          y_next     = fin_y;
          zero_next  = fin_zero;
          ovf_next   = fin_ovf;
          state_next = DONE;
        end
      end
      DONE: begin
        if (retire)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sgn_reg    <= 1'b0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      y_reg      <= '0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sgn_reg    <= sgn_next;
      neg_reg    <= neg_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      y_reg      <= y_next;
      zero_reg   <= zero_next;
      ovf_reg    <= ovf_next;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [19:0] y;
    logic        zero;
    logic        ovf;
    int          lat;
    int          acc_cyc;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [2:0]  sel;
    logic        sgn;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   last_retire = 0;
  bit   front_seen = 0;
  bit   chk_en = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic, then range/saturation rules.
  function automatic void model(input logic [9:0] a, input logic [9:0] b, input logic [2:0] sel,
                                input logic sgn, output logic [19:0] y, output logic ovf,
                                output int lat);
    longint va, vb, r;
    va  = sgn ? longint'($signed(a)) : longint'(a);
    vb  = sgn ? longint'($signed(b)) : longint'(b);
    r   = 0;
    ovf = 1'b0;
    lat = (sel == 3'd2) ? W + 1 : 1;
    case (sel)
      3'd0: r = va + vb;
      3'd1: r = va - vb;
      3'd2: r = va * vb;
      3'd3: r = longint'(a ^ b);
      3'd4: r = longint'(a & b);
      3'd5: r = longint'(a | b);
      3'd6: r = (b >= 20) ? 0 : (longint'(a) << b);
      default: begin
        if (!sgn) r = (b >= 10) ? 0 : (longint'(a) >> b);
        else      r = (b >= 10) ? ((va < 0) ? -1 : 0) : (va >>> b);
      end
    endcase
    if (sel <= 3'd2) begin
      if (sgn) ovf = (r < -512) || (r > 511);
      else     ovf = (r < 0) || (r > 1023);
`ifdef ALU_SAT_EN
      if (ovf) r = sgn ? ((r < 0) ? -512 : 511) : ((r < 0) ? 0 : 1023);
`endif
    end
    y = r[19:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Compare process: every cycle, DUT handshake and result against the model queue.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("in_ready_rst", bus.in_ready, 0);
        q.delete();
        front_seen = 0;
      end else begin
        chk("in_ready", bus.in_ready, q.size() == 0);
        if (q.size() == 0) begin
          chk("out_valid_idle", bus.out_valid, 0);
        end else if (bus.out_valid) begin
          e = q[0];
          chk("y", bus.y, e.y);
          chk("zero", bus.zero, e.zero);
          chk("ovf", bus.ovf, e.ovf);
          if (!front_seen) begin
            chk("latency", cyc - e.acc_cyc, e.lat);
            front_seen = 1;
          end
          if (bus.out_ready) begin
            $display("txn sel=%0d sgn=%0d a=%03h b=%03h -> y=%05h zero=%0d ovf=%0d",
                     e.sel, e.sgn, e.a, e.b, bus.y, bus.zero, bus.ovf);
            void'(q.pop_front());
            front_seen  = 0;
            last_retire = cyc;
          end
        end else if (front_seen) begin
          chk("out_valid_held", bus.out_valid, 1);
        end
        if (bus.in_valid && bus.in_ready) begin
          e.a = bus.a; e.b = bus.b; e.sel = bus.sel; e.sgn = bus.sgn;
          model(bus.a, bus.b, bus.sel, bus.sgn, e.y, e.ovf, e.lat);
          e.zero    = (e.y == 20'd0);
          e.acc_cyc = cyc;
          q.push_back(e);
          last_acc = cyc;
        end
      end
    end
  end

  task automatic drive_op(input logic [9:0] a, input logic [9:0] b, input logic [2:0] sel,
                          input logic sgn);
    bus.a = a; bus.b = b; bus.sel = sel; bus.sgn = sgn;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1;
    end
    if (!ok) chk("result_timeout", bus.out_valid, 1);
  endtask

  task automatic run_directed(input string name, input logic [9:0] a, input logic [9:0] b,
                              input logic [2:0] sel, input logic sgn, input logic [19:0] exp_y,
                              input logic exp_zero, input logic exp_ovf, input int exp_lat);
    drive_op(a, b, sel, sgn);
    wait_accept();
    wait_valid();
    chk({name, "_y"}, bus.y, exp_y);
    chk({name, "_zero"}, bus.zero, exp_zero);
    chk({name, "_ovf"}, bus.ovf, exp_ovf);
    chk({name, "_lat"}, cyc - last_acc, exp_lat);
    @(posedge clk);
    #1;
  endtask

  logic [19:0] my;
  logic        mo;
  int          ml;
  bit          done;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.sgn = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1);

    // Pin the model with hand-computed values.
    model(10'd1023, 10'd1023, 3'd0, 1'b0, my, mo, ml);
`ifdef ALU_SAT_EN
    chk("pin_add_y", my, 20'd1023);
`else
    chk("pin_add_y", my, 20'd2046);
`endif
    chk("pin_add_ovf", mo, 1);
    model(10'h3F6, 10'd5, 3'd1, 1'b1, my, mo, ml);
    chk("pin_ssub_y", my, 20'hFFFF1);
    model(10'h3FA, 10'd3, 3'd2, 1'b1, my, mo, ml);
    chk("pin_smul_y", my, 20'hFFFEE);
    chk("pin_smul_lat", ml, 11);
    model(10'd682, 10'd2, 3'd7, 1'b1, my, mo, ml);
    chk("pin_sra_y", my, 20'hFFFAA);

    // Directed cases.
    @(posedge clk); #1;
`ifdef ALU_SAT_EN
    run_directed("add_max", 10'd1023, 10'd1023, 3'd0, 1'b0, 20'd1023, 1'b0, 1'b1, 1);
`else
    run_directed("add_max", 10'd1023, 10'd1023, 3'd0, 1'b0, 20'd2046, 1'b0, 1'b1, 1);
`endif
    run_directed("sub_zero", 10'd0, 10'd0, 3'd1, 1'b0, 20'd0, 1'b1, 1'b0, 1);
    run_directed("ssub", 10'h3F6, 10'd5, 3'd1, 1'b1, 20'hFFFF1, 1'b0, 1'b0, 1);
    run_directed("mul", 10'd20, 10'd4, 3'd2, 1'b0, 20'd80, 1'b0, 1'b0, 11);
    run_directed("smul", 10'h3FA, 10'd3, 3'd2, 1'b1, 20'hFFFEE, 1'b0, 1'b0, 11);
    run_directed("shl", 10'd682, 10'd3, 3'd6, 1'b0, 20'd5456, 1'b0, 1'b0, 1);
    run_directed("sra", 10'd682, 10'd2, 3'd7, 1'b1, 20'hFFFAA, 1'b0, 1'b0, 1);
    run_directed("srl", 10'd682, 10'd2, 3'd7, 1'b0, 20'd170, 1'b0, 1'b0, 1);
    run_directed("shl_big", 10'd682, 10'd20, 3'd6, 1'b0, 20'd0, 1'b1, 1'b0, 1);
    run_directed("sra_big", 10'd682, 10'd15, 3'd7, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 1);
    run_directed("srl_big", 10'd682, 10'd10, 3'd7, 1'b0, 20'd0, 1'b1, 1'b0, 1);

    // Backpressure: result stalls with the next op already waiting.
    ready_mode = 2;
    @(posedge clk); #1;
    drive_op(10'd100, 10'd23, 3'd0, 1'b0);
    wait_accept();
    drive_op(10'd50, 10'd7, 3'd1, 1'b0);
    repeat (5) @(negedge clk);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_y", bus.y, 20'd123);
    ready_mode = 0;
    wait_accept();
    chk("bp_accept_after_retire", last_acc - last_retire, 1);
    wait_valid();
    chk("bp_second_y", bus.y, 20'd43);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    drive_op(10'd20, 10'd4, 3'd2, 1'b0);
    wait_accept();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    run_directed("post_rst_add", 10'd31, 10'd3, 3'd0, 1'b0, 20'd34, 1'b0, 1'b0, 1);

    // Randomized traffic with random consumer stalls.
    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic [9:0] ra, rb;
      ra = 10'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 24)) : 10'($urandom);
      drive_op(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom));
      wait_accept();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    ready_mode = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
